pool_port_sched_2: RTL and testbench

Sequencer and port arbiter for the layer-2 pooled-output memories (`pool_memo_2` bank, one per multiplier lane). It grants the shared dual-port address/strobe bus to exactly one owner at a time:
- the layer's own pool write-back while layer 2 is computing;
- the next layer's reader once the frame is complete.

It also produces the layer-2 enable/clear and next-layer enable that sequence the hand-off. Its memory-side outputs drive the `*_use_out` inputs of the layer-2 top.

---
 rtl/pool_port_sched_2_pkg.sv | 12 +
 rtl/pool_port_sched_2_sat_strobe_cnt.sv | 29 ++
 rtl/pool_port_sched_2.sv | 100 ++++++++++
 tb/tb_pool_port_sched_2.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_port_sched_2_pkg.sv
// pool_port_sched_2_pkg: shared state encoding and default widths for pool port schedulers
package pool_port_sched_2_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRODUCE = 2'd1,
        ST_FULL    = 2'd2,
        ST_CONSUME = 2'd3
    } sched_state_e;

    localparam int POOL_ADDR_WIDTH_DEF = 10;
    localparam int WCNT_WIDTH_DEF      = 12;
endpackage

// File: rtl/pool_port_sched_2_sat_strobe_cnt.sv
// sat_strobe_cnt: saturating counter adding up to two strobes per cycle
module sat_strobe_cnt #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc0,
    input  logic             inc1,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // next count: clear wins, otherwise add strobes and clamp at all-ones
    always_comb begin
        sum   = {1'b0, cnt_q} + {{WIDTH{1'b0}}, inc0} + {{WIDTH{1'b0}}, inc1};
        cnt_d = clr ? '0 : en ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) : cnt_q;
    end

    // count register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;
endmodule

// File: rtl/pool_port_sched_2.sv
// pool_port_sched_2: layer-2 pool memory port arbiter and layer hand-off sequencer
module pool_port_sched_2
    import pool_port_sched_2_pkg::*;
#(
    parameter int POOL_ADDR_WIDTH = POOL_ADDR_WIDTH_DEF,
    parameter int WCNT_WIDTH      = WCNT_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prod_start,
    input  logic                       prod_done,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_address_a,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_address_b,
    input  logic                       prod_rden_a,
    input  logic                       prod_rden_b,
    input  logic                       prod_wren_a,
    input  logic                       prod_wren_b,
    input  logic                       cons_req,
    input  logic                       cons_done,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_address_a,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_address_b,
    input  logic                       cons_rden_a,
    input  logic                       cons_rden_b,
    output logic [POOL_ADDR_WIDTH-1:0] mem_address_a,
    output logic [POOL_ADDR_WIDTH-1:0] mem_address_b,
    output logic                       mem_rden_a,
    output logic                       mem_rden_b,
    output logic                       mem_wren_a,
    output logic                       mem_wren_b,
    output logic                       layer_enable,
    output logic                       layer_clear,
    output logic                       next_enable,
    output logic [WCNT_WIDTH-1:0]      frame_words,
    output logic [1:0]                 state,
    output logic                       err_access
);
    sched_state_e state_q, state_d;
    logic         clear_q, clear_d;
    logic         err_q, err_d;
    logic         prod_own, cons_own, start_frame;

    assign prod_own    = state_q == ST_PRODUCE;
    assign cons_own    = state_q == ST_CONSUME;
    assign start_frame = state_q == ST_IDLE && prod_start;

    // next state, first-cycle clear pulse and sticky blocked-strobe flag
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (prod_start) state_d = ST_PRODUCE;
            ST_PRODUCE: if (prod_done)  state_d = ST_FULL;
            ST_FULL:    if (cons_req)   state_d = ST_CONSUME;
            ST_CONSUME: if (cons_done)  state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        clear_d = start_frame;
        err_d   = err_q
                | (!prod_own && (prod_rden_a || prod_rden_b || prod_wren_a || prod_wren_b))
                | (!cons_own && (cons_rden_a || cons_rden_b));
    end

    // state and flag registers; reset overrides any transition
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
            err_q   <= err_d;
        end
    end

    // bus mux from the registered owner; consumer never writes, idle/full drive zero
    always_comb begin
        mem_address_a = prod_own ? prod_address_a : cons_own ? cons_address_a : '0;
        mem_address_b = prod_own ? prod_address_b : cons_own ? cons_address_b : '0;
        mem_rden_a    = prod_own ? prod_rden_a : cons_own & cons_rden_a;
        mem_rden_b    = prod_own ? prod_rden_b : cons_own & cons_rden_b;
        mem_wren_a    = prod_own & prod_wren_a;
        mem_wren_b    = prod_own & prod_wren_b;
    end

    sat_strobe_cnt #(.WIDTH(WCNT_WIDTH)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc0  (prod_wren_a),
        .inc1  (prod_wren_b),
        .clr   (start_frame),
        .en    (prod_own),
        .count (frame_words)
    );

    assign layer_enable = prod_own;
    assign layer_clear  = clear_q;
    assign next_enable  = cons_own;
    assign state        = state_q;
    assign err_access   = err_q;
endmodule

// File: tb/tb_pool_port_sched_2.sv
// tb_pool_port_sched_2: directed hand-off sequence plus random traffic against a rule model
module tb_pool_port_sched_2;
    logic       clock = 0, reset = 1;
    logic       prod_start, prod_done, prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b;
    logic       cons_req, cons_done, cons_rden_a, cons_rden_b;
    logic [9:0] prod_address_a, prod_address_b, cons_address_a, cons_address_b;
    logic [9:0] mem_address_a, mem_address_b, m4_address_a, m4_address_b;
    logic       mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b;
    logic       m4_rden_a, m4_rden_b, m4_wren_a, m4_wren_b;
    logic       layer_enable, layer_clear, next_enable, err_access;
    logic       le4, lc4, ne4, err4;
    logic [11:0] frame_words;
    logic [3:0]  fw4;
    logic [1:0]  state, st4;
    int vectors = 0, errors = 0;
    int m_state, m_words, m_words4;
    bit m_clear, m_err;

    always #5 clock = ~clock;

    pool_port_sched_2 dut (
        .clock(clock), .reset(reset), .prod_start(prod_start), .prod_done(prod_done),
        .prod_address_a(prod_address_a), .prod_address_b(prod_address_b),
        .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
        .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
        .cons_req(cons_req), .cons_done(cons_done),
        .cons_address_a(cons_address_a), .cons_address_b(cons_address_b),
        .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
        .mem_address_a(mem_address_a), .mem_address_b(mem_address_b),
        .mem_rden_a(mem_rden_a), .mem_rden_b(mem_rden_b),
        .mem_wren_a(mem_wren_a), .mem_wren_b(mem_wren_b),
        .layer_enable(layer_enable), .layer_clear(layer_clear), .next_enable(next_enable),
        .frame_words(frame_words), .state(state), .err_access(err_access)
    );

    pool_port_sched_2 #(.WCNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .prod_start(prod_start), .prod_done(prod_done),
        .prod_address_a(prod_address_a), .prod_address_b(prod_address_b),
        .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
        .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
        .cons_req(cons_req), .cons_done(cons_done),
        .cons_address_a(cons_address_a), .cons_address_b(cons_address_b),
        .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
        .mem_address_a(m4_address_a), .mem_address_b(m4_address_b),
        .mem_rden_a(m4_rden_a), .mem_rden_b(m4_rden_b),
        .mem_wren_a(m4_wren_a), .mem_wren_b(m4_wren_b),
        .layer_enable(le4), .layer_clear(lc4), .next_enable(ne4),
        .frame_words(fw4), .state(st4), .err_access(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        {prod_start, prod_done, prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = '0;
        {cons_req, cons_done, cons_rden_a, cons_rden_b} = '0;
        {prod_address_a, prod_address_b, cons_address_a, cons_address_b} = '0;
    endtask

    task automatic check_outputs();
        logic [9:0] ea, eb;
        logic       ra, rb, wa, wb;
        ea = 0; eb = 0; ra = 0; rb = 0; wa = 0; wb = 0;
        if (m_state == 1) begin
            ea = prod_address_a; eb = prod_address_b;
            ra = prod_rden_a; rb = prod_rden_b; wa = prod_wren_a; wb = prod_wren_b;
        end else if (m_state == 3) begin
            ea = cons_address_a; eb = cons_address_b; ra = cons_rden_a; rb = cons_rden_b;
        end
        chk("mux", {8'd0, mem_address_a, mem_address_b, mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b},
            {8'd0, ea, eb, ra, rb, wa, wb});
        chk("seq", {26'd0, layer_enable, layer_clear, next_enable, state, err_access},
            {26'd0, m_state == 1, m_clear, m_state == 3, 2'(m_state), m_err});
        chk("words", 32'(frame_words), 32'(m_words));
        chk("mux4", {8'd0, m4_address_a, m4_address_b, m4_rden_a, m4_rden_b, m4_wren_a, m4_wren_b},
            {8'd0, ea, eb, ra, rb, wa, wb});
        chk("seq4", {26'd0, le4, lc4, ne4, st4, err4},
            {26'd0, m_state == 1, m_clear, m_state == 3, 2'(m_state), m_err});
        chk("words4", 32'(fw4), 32'(m_words4));
    endtask

    task automatic model_update();
        int inc;
        inc = int'(prod_wren_a) + int'(prod_wren_b);
        if (reset) begin
            m_state = 0; m_clear = 0; m_err = 0; m_words = 0; m_words4 = 0;
            return;
        end
        m_clear = m_state == 0 && prod_start;
        if ((m_state != 1 && (prod_rden_a || prod_rden_b || prod_wren_a || prod_wren_b)) ||
            (m_state != 3 && (cons_rden_a || cons_rden_b))) m_err = 1;
        if (m_state == 0 && prod_start) begin
            m_words = 0; m_words4 = 0;
        end else if (m_state == 1) begin
            m_words  = (m_words + inc > 4095) ? 4095 : m_words + inc;
            m_words4 = (m_words4 + inc > 15) ? 15 : m_words4 + inc;
        end
        if      (m_state == 0 && prod_start) m_state = 1;
        else if (m_state == 1 && prod_done)  m_state = 2;
        else if (m_state == 2 && cons_req)   m_state = 3;
        else if (m_state == 3 && cons_done)  m_state = 0;
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        clr_in();
        m_state = 0; m_clear = 0; m_err = 0; m_words = 0; m_words4 = 0;
        reset = 1;
        @(posedge clock); model_update(); #1;
        step();
        reset = 0;
        chk("rst_state", 32'(state), 0);
        chk("rst_words", 32'(frame_words), 0);

        prod_start = 1; step(); prod_start = 0;
        chk("start_state", 32'(state), 1);
        chk("start_en", 32'(layer_enable), 1);
        chk("start_clear", 32'(layer_clear), 1);
        step();
        chk("clear_drop", 32'(layer_clear), 0);

        for (int i = 0; i < 10; i++) begin
            prod_wren_a = 1; prod_wren_b = 1; prod_address_a = 10'h005; prod_address_b = 10'h006;
            #1;
            chk("wr_addr_b", 32'(mem_address_b), 32'h006);
            step();
        end
        clr_in(); prod_done = 1; step(); prod_done = 0;
        chk("full_state", 32'(state), 2);
        chk("full_words", 32'(frame_words), 20);

        cons_req = 1; cons_rden_a = 1; cons_address_a = 10'h3FF;
        #1;
        chk("full_rden_blk", 32'(mem_rden_a), 0);
        step(); cons_req = 0;
        chk("cons_state", 32'(state), 3);
        chk("cons_next_en", 32'(next_enable), 1);
        chk("cons_addr", 32'(mem_address_a), 32'h3FF);
        chk("cons_wren", 32'({mem_wren_a, mem_wren_b}), 0);
        chk("err_set", 32'(err_access), 1);

        prod_wren_a = 1; prod_start = 1;
        #1;
        chk("cons_wr_blk", 32'(mem_wren_a), 0);
        step();
        clr_in();
        chk("cons_hold", 32'(state), 3);
        chk("err_sticky", 32'(err_access), 1);
        cons_done = 1; step(); cons_done = 0;
        chk("back_idle", 32'(state), 0);

        prod_start = 1; step(); clr_in();
        for (int i = 0; i < 3; i++) begin
            prod_wren_a = 1; prod_wren_b = 1; step();
        end
        reset = 1; step(); reset = 0;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_words", 32'(frame_words), 0);
        chk("midrst_wren", 32'({mem_wren_a, mem_wren_b, layer_enable, err_access}), 0);
        clr_in();

        prod_start = 1; step(); clr_in();
        for (int i = 0; i < 10; i++) begin
            prod_wren_a = 1; prod_wren_b = 1; step();
        end
        clr_in();
        chk("sat4", 32'(fw4), 15);
        chk("nosat12", 32'(frame_words), 20);

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(63) == 0);
            prod_start     = ($urandom_range(3) == 0);
            prod_done      = ($urandom_range(7) == 0);
            cons_req       = ($urandom_range(3) == 0);
            cons_done      = ($urandom_range(7) == 0);
            prod_rden_a    = 1'($urandom); prod_rden_b = 1'($urandom);
            prod_wren_a    = ($urandom_range(3) != 0); prod_wren_b = ($urandom_range(3) != 0);
            cons_rden_a    = 1'($urandom); cons_rden_b = 1'($urandom);
            prod_address_a = 10'($urandom); prod_address_b = 10'($urandom);
            cons_address_a = 10'($urandom); cons_address_b = 10'($urandom);
            step();
        end
        reset = 0; clr_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
